// File: rtl/jio_pkg.sv
// Shared IO-protocol encodings, status-byte layout and device addresses for the JIO bus responders.
package jio_pkg;

  typedef enum logic {IO_DATA = 1'b0, IO_ADDR = 1'b1} io_da_e;
  typedef enum logic {IO_IN = 1'b0, IO_OUT = 1'b1} io_dir_e;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_CNT_LO = 4;

  localparam logic [7:0] DEV_TTY = 8'h00;
  localparam logic [7:0] DEV_KBD = 8'h01;

  function automatic logic [7:0] status_byte(input logic [4:0] count, input logic ovf,
                                             input logic full, input logic empty);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_CNT_LO +: 4] = count[3:0];
    s[STAT_OVF]         = ovf;
    s[STAT_FULL]        = full;
    s[STAT_NEMPTY]      = ~empty;
    return s;
  endfunction

endpackage

// File: rtl/jio_fifo.sv
// Byte FIFO for the keyboard responder; head is a combinational view of the oldest entry.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps count.
module jio_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [4:0]   o_count,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == 5'd0);
  assign o_full    = (r_count == 5'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 5'd0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/jio_kbd.sv
// Keyboard IO responder: selectable by address, queues strobed key bytes, returns them on data reads.
// Optional status byte / sticky overflow flag built only with JIO_KBD_STATUS_EN defined.
module jio_kbd
  import jio_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEV_KBD,
  parameter int         DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] bus_in,
  input  logic       io_s,
  input  logic       io_e,
  input  logic       io_da,
  input  logic       io_io,
  input  logic [7:0] key_data,
  input  logic       key_strobe,
  output logic [7:0] bus_out,
  output logic       key_ready
);

  logic       r_io_s_d;
  logic [7:0] r_dev_addr;
  logic       r_ks_s1;
  logic       r_ks_s2;
  logic       r_ks_s3;
  logic       r_data_pend;
  logic       w_sel;
  logic       w_push;
  logic       w_pop;
  logic       w_data_rd;
  logic [7:0] w_head;
  logic [4:0] w_count;
  logic       w_empty;
  logic       w_full;

  assign w_sel     = (r_dev_addr == DEV_ADDR);
  assign w_push    = r_ks_s2 & ~r_ks_s3;
  assign w_data_rd = io_e && w_sel && (io_da == IO_DATA) && (io_io == IO_IN);
  // A read is consumed on the first clock that sees io_e low after it was seen.
  assign w_pop     = r_data_pend & ~io_e;
  assign key_ready = (w_count != 5'd0);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_io_s_d    <= 1'b0;
      r_dev_addr  <= 8'h00;
      r_ks_s1     <= 1'b0;
      r_ks_s2     <= 1'b0;
      r_ks_s3     <= 1'b0;
      r_data_pend <= 1'b0;
    end else begin
      r_io_s_d <= io_s;
      if (io_s && !r_io_s_d && (io_da == IO_ADDR) && (io_io == IO_OUT))
        r_dev_addr <= bus_in;
      r_ks_s1 <= key_strobe;
      r_ks_s2 <= r_ks_s1;
      r_ks_s3 <= r_ks_s2;
      if (w_data_rd)   r_data_pend <= 1'b1;
      else if (!io_e)  r_data_pend <= 1'b0;
    end
  end

  jio_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .CLK        (CLK),
    .reset      (reset),
    .i_push     (w_push & ~w_full),
    .i_push_dat (key_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

`ifdef JIO_KBD_STATUS_EN
  logic       r_stat_pend;
  logic       r_ovf;
  logic       w_stat_rd;
  logic [7:0] w_status;

  assign w_stat_rd = io_e && w_sel && (io_da == IO_ADDR) && (io_io == IO_IN);
  assign w_status  = status_byte(w_count, r_ovf, w_full, w_empty);

  // A new overflow on the clearing clock wins so no drop goes unreported.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_stat_pend <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_stat_rd)  r_stat_pend <= 1'b1;
      else if (!io_e) r_stat_pend <= 1'b0;
      if (w_push && w_full)          r_ovf <= 1'b1;
      else if (r_stat_pend && !io_e) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    bus_out = 8'h00;
    if (w_data_rd && !w_empty) bus_out = w_head;
    else if (w_stat_rd)        bus_out = w_status;
  end
`else
  always_comb begin
    bus_out = 8'h00;
    if (w_data_rd && !w_empty) bus_out = w_head;
  end
`endif

endmodule

// File: tb/tb_jio_kbd.sv
// Scoreboarded bench for jio_kbd: read strobes queue expected bus bytes, a monitor compares them.
module tb_jio_kbd;
  import jio_pkg::*;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       io_s, io_e, io_da, io_io;
  logic [7:0] key_data;
  logic       key_strobe;
  logic [7:0] bus_out;
  logic       key_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       mon_prev_e = 1'b0;

  jio_kbd #(.DEV_ADDR(8'h01), .DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .bus_in(bus_in), .io_s(io_s), .io_e(io_e),
    .io_da(io_da), .io_io(io_io), .key_data(key_data), .key_strobe(key_strobe),
    .bus_out(bus_out), .key_ready(key_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] st(input logic [7:0] v);
`ifdef JIO_KBD_STATUS_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: compare bus_out once per io_e window, at the first falling edge it is seen high.
  always @(negedge CLK) begin
    if (io_e && !mon_prev_e) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read bus_out=%h with no expectation queued", bus_out);
      end else begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus_out !== e) begin
          errors++;
          $display("FAIL %s bus_out=%h expected %h", n, bus_out, e);
        end
      end
    end
    mon_prev_e = io_e;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    @(negedge CLK);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
    tick(1);
  endtask

  task automatic select(input logic [7:0] a);
    bus_in = a; io_da = 1'b1; io_io = 1'b1; io_s = 1'b1;
    tick(2);
    io_s = 1'b0; bus_in = 8'h00;
    tick(1);
  endtask

  task automatic strobe(input logic [7:0] d);
    key_data = d; key_strobe = 1'b1;
    tick(1);
    key_strobe = 1'b0;
    tick(4);
  endtask

  task automatic rd(input string n, input logic da, input logic [7:0] exp);
    exp_q.push_back(exp); name_q.push_back(n);
    io_da = da; io_io = 1'b0; io_e = 1'b1;
    tick(2);
    io_e = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1; bus_in = 8'h00; io_s = 1'b0; io_e = 1'b0; io_da = 1'b0; io_io = 1'b0;
    key_data = 8'h00; key_strobe = 1'b0;
    tick(3);
    chk("reset_bus_out", bus_out, 8'h00);
    chk("reset_key_ready", {7'd0, key_ready}, 8'h00);
    reset = 1'b0;
    tick(2);

    // Basic select, push and data read.
    select(DEV_KBD);
    strobe(8'h41);
    chk("ready_after_push", {7'd0, key_ready}, 8'h01);
    rd("read_41", IO_DATA, 8'h41);
    chk("ready_after_pop", {7'd0, key_ready}, 8'h00);
    rd("read_empty", IO_DATA, 8'h00);

    // Deselected: reads are silent and nothing is popped.
    select(DEV_TTY);
    strobe(8'h55);
    rd("tty_read", IO_DATA, 8'h00);
    rd("tty_status", IO_ADDR, 8'h00);
    chk("tty_no_pop", {7'd0, key_ready}, 8'h01);
    select(DEV_KBD);
    rd("status_count1", IO_ADDR, st(8'h11));
    rd("read_55", IO_DATA, 8'h55);
    chk("ready_drained", {7'd0, key_ready}, 8'h00);

    // Overflow: fifth byte dropped, sticky flag cleared by a status read.
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    rd("status_ovf", IO_ADDR, st(8'h47));
    rd("status_ovf_cleared", IO_ADDR, st(8'h43));
    for (int i = 1; i <= 4; i++) rd($sformatf("ovf_read_%0d", i), IO_DATA, 8'(i));
    rd("ovf_read_dropped", IO_DATA, 8'h00);
    rd("status_empty", IO_ADDR, 8'h00);

    // Output write is ignored: no bus drive and no pop.
    strobe(8'h66);
    exp_q.push_back(8'h00); name_q.push_back("write_ignored");
    io_da = IO_DATA; io_io = IO_OUT; bus_in = 8'h99; io_e = 1'b1;
    tick(2);
    io_e = 1'b0; bus_in = 8'h00;
    tick(2);
    chk("write_no_pop", {7'd0, key_ready}, 8'h01);
    rd("read_66", IO_DATA, 8'h66);

    // Push and pop land on the same clock with two entries queued.
    strobe(8'hAA);
    strobe(8'hBB);
    exp_q.push_back(8'hAA); name_q.push_back("pp_read_AA");
    io_da = IO_DATA; io_io = IO_IN; io_e = 1'b1;
    tick(1);
    key_data = 8'hCC; key_strobe = 1'b1;
    tick(1);
    key_strobe = 1'b0;
    tick(1);
    io_e = 1'b0;
    tick(4);
    rd("pp_status_count2", IO_ADDR, st(8'h21));
    rd("pp_read_BB", IO_DATA, 8'hBB);
    rd("pp_read_CC", IO_DATA, 8'hCC);
    chk("pp_drained", {7'd0, key_ready}, 8'h00);

    // Reset in the middle of a read discards the pending pop.
    strobe(8'h77);
    exp_q.push_back(8'h77); name_q.push_back("pre_reset_read");
    io_da = IO_DATA; io_io = IO_IN; io_e = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("mid_reset_bus_out", bus_out, 8'h00);
    reset = 1'b0;
    tick(1);
    io_e = 1'b0;
    tick(3);
    chk("post_reset_bus_out", bus_out, 8'h00);
    chk("post_reset_key_ready", {7'd0, key_ready}, 8'h00);

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jio_kbd.md
JIO_KBD -- requirements
Module: jio_kbd

Interface
REQ-001 Parameter DEV_ADDR, default 8'h01: IO device address this responder answers to.
REQ-002 Parameter DEPTH, default 4, power of two 2..16: input FIFO depth in bytes.
REQ-003 CLK  in  1: single system clock; all state changes on its rising edge.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 bus_in  in  8: CPU data bus value.
REQ-006 io_s, io_e, io_da, io_io  in  1 each: CU IO controls; io_da=1 address / 0 data; io_io=1 output (CPU->device) / 0 input (device->CPU).
REQ-007 key_data  in  8: byte presented by the keyboard/switch source.
REQ-008 key_strobe  in  1: asynchronous push request; a rising edge pushes key_data.
REQ-009 bus_out  out  8: byte driven onto the wired-OR bus; SHALL be 8'h00 whenever not driving.
REQ-010 key_ready  out  1: high while the FIFO is non-empty.

Function
REQ-011 Address select SHALL occur on an io_s rising edge, sampled in CLK, with io_da=1 and io_io=1: dev_addr <= bus_in; sel = (dev_addr == DEV_ADDR).
REQ-012 Data read SHALL occur while io_e=1, io_da=0, io_io=0 and sel: bus_out = FIFO head combinationally; 8'h00 if empty.
REQ-013 Pop SHALL occur exactly once per data read, on the first CLK after io_e falls following a selected data read; no pop if empty.
REQ-014 Status read SHALL occur while io_e=1, io_da=1, io_io=0 and sel: bus_out = {count[3:0], 1'b0, ovf, full, ~empty}.
REQ-015 ovf SHALL be sticky; set on push-while-full; cleared on the CLK after io_e falls following a status read.
REQ-016 key_strobe SHALL pass through a 2-FF synchronizer; key_data SHALL be captured on the synchronized rising edge, and the push occurs in that same cycle.
REQ-017 Push-while-full SHALL drop the byte and leave the FIFO unchanged.
REQ-018 Simultaneous push and pop SHALL both complete, count unchanged; when empty, only the push.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-020 Output writes (io_io=1, io_da=0) SHALL be ignored by this block.
REQ-021 Not selected: bus_out=0 and no pop/clear, regardless of io_e.

Reset
REQ-022 Reset SHALL force: FIFO empty, pointers 0, ovf=0, dev_addr=8'h00, sel=(8'h00==DEV_ADDR), synchronizer and edge detectors 0, key_ready=0, bus_out=0.
REQ-023 Reset during a read SHALL discard the pending pop; no pop after reset release.

Configuration
REQ-024 Macro JIO_KBD_STATUS_EN defined: status read per REQ-014/015.
REQ-025 Macro undefined: status reads drive 8'h00; ovf logic absent; overflow drops are silent.

Structure
REQ-026 Package jio_pkg SHALL hold the IO mode encodings (ADDR/DATA, IN/OUT), the status bit positions, and the default TTY (8'h00) and KBD (8'h01) device addresses.
REQ-027 FIFO SHALL be sub-module jio_fifo (DEPTH parameter; push, pop, head, count, empty, full); selection, edge detection and status logic live in jio_kbd.

Verification
REQ-028 Reset; select 8'h01; strobe key_data=8'h41; data read -> bus_out=8'h41 during io_e, key_ready=0 after pop.
REQ-029 Select 8'h00 (TTY); strobe 8'h55; data read -> bus_out=8'h00, FIFO count stays 1.
REQ-030 Push 8'h01..8'h05 with DEPTH=4 -> reads return 01,02,03,04 then 8'h00; status before reads = 8'h47.
REQ-031 Status read after overflow -> ovf=1; second status read -> ovf=0.
REQ-032 Push and pop in the same CLK with count=2 -> count=2, correct order preserved.
REQ-033 Assert reset mid-read with io_e high -> no pop after release, bus_out=0, key_ready=0.
